// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered 8N1 UART transmitter with back-to-back frame chaining
module uart_tx_ctrl #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_ctrl: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, pop, push;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;

    assign in_ready = rst && (fifo_count != FULL);
    assign push     = in_valid && in_ready;
    assign busy     = (fifo_count != '0) || (state != IDLE);

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            fifo_count <= (push && !pop) ? fifo_count + 1'b1 :
                          (pop && !push) ? fifo_count - 1'b1 : fifo_count;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

    // Frame state, baud counter, shifter and registered line output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            tx    <= tx_n;
        end
    end

    // Next state; tx_n is the level of the state being entered so tx needs no extra stage
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                pop     = fifo_count != '0;
                state_n = pop ? START : IDLE;
                shift_n = pop ? mem[rptr] : shift;
                tx_n    = !pop;
            end
            START: begin
                if (cnt == LAST) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = (idx == 3'd7) ? STOP : DATA;
                    idx_n   = idx + 1'b1;
                    shift_n = {1'b0, shift[7:1]};
                    tx_n    = (idx == 3'd7) ? 1'b1 : shift[1];
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    pop     = fifo_count != '0;
                    state_n = pop ? START : IDLE;
                    shift_n = pop ? mem[rptr] : shift;
                    tx_n    = !pop;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: vector table, directed corner sequences and random traffic against a frame-level model
module tb_uart_tx_ctrl;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, tx, busy;
    logic [2:0] fifo_count;

    int passed = 0;
    int total  = 0;

    logic [7:0] q[$];
    bit         wave[$];

    typedef struct {
        bit         v;
        logic [7:0] d;
        int         n;
        bit         tx;
        bit         busy;
        int         cnt;
        bit         rdy;
    } vec_t;
    vec_t tbl[12];

    uart_tx_ctrl #(.CLK_FREQ_HZ(1000), .BAUD_RATE(250), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        wave.delete();
    endtask

    // One clock with the reference model: a byte queue plus the expected line waveform of the current frame
    task automatic cyc(input bit v, input logic [7:0] d, output bit acc);
        bit         act, exp_tx;
        logic [7:0] b;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        acc = v && (q.size() != DEPTH);
        if (wave.size() == 0 && q.size() != 0) begin
            b = q.pop_front();
            repeat (CPB) wave.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) wave.push_back(b[i]);
            repeat (CPB) wave.push_back(1'b1);
        end
        if (acc) q.push_back(d);
        act    = wave.size() != 0;
        exp_tx = act ? wave.pop_front() : 1'b1;
        #1;
        chk("tx", int'(tx), int'(exp_tx));
        chk("busy", int'(busy), int'(act || q.size() != 0));
        chk("fifo_count", int'(fifo_count), q.size());
        chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
    endtask

    task automatic drain(input string nm);
        int n = 0;
        bit a;
        while ((busy || wave.size() != 0 || q.size() != 0) && n < 600) begin
            cyc(1'b0, 8'h00, a);
            n++;
        end
        chk(nm, int'(n < 600), 1);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_tx"}, int'(tx), 1);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_count"}, int'(fifo_count), 0);
        chk({nm, "_ready"}, int'(in_ready), 0);
    endtask

    initial begin
        bit         a;
        int         k, n, maxc;
        logic [7:0] six [6] = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E};

        tbl[0]  = '{1'b1, 8'hA5, 1, 1'b1, 1'b1, 1, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 4, 1'b0, 1'b1, 0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 4, 1'b1, 1'b1, 0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 4, 1'b0, 1'b1, 0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 4, 1'b1, 1'b1, 0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 4, 1'b0, 1'b1, 0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 4, 1'b0, 1'b1, 0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 4, 1'b1, 1'b1, 0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 4, 1'b0, 1'b1, 0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 4, 1'b1, 1'b1, 0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 4, 1'b1, 1'b1, 0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 3, 1'b1, 0,    0, 1'b1};

        #1 rst = 1'b0;
        #1 chk_reset("rst_async");
        #20 chk_reset("rst_held");
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rst", int'(in_ready), 1);

        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                in_valid = (c == 0) && tbl[i].v;
                in_data  = tbl[i].d;
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d.%0d_tx", i, c), int'(tx), int'(tbl[i].tx));
                chk($sformatf("vec%0d.%0d_busy", i, c), int'(busy), int'(tbl[i].busy));
                chk($sformatf("vec%0d.%0d_count", i, c), int'(fifo_count), tbl[i].cnt);
                chk($sformatf("vec%0d.%0d_ready", i, c), int'(in_ready), int'(tbl[i].rdy));
            end
        end
        in_valid = 1'b0;

        model_reset();
        cyc(1'b1, 8'h01, a);
        cyc(1'b1, 8'h02, a);
        cyc(1'b1, 8'h03, a);
        drain("drain_three");

        k = 0; n = 0; maxc = 0;
        while (k < 6 && n < 400) begin
            cyc(1'b1, six[k], a);
            if (a) k++;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            n++;
        end
        chk("six_accepted", k, 6);
        chk("six_max_count", maxc, DEPTH);
        drain("drain_six");

        cyc(1'b1, 8'h11, a);
        cyc(1'b1, 8'h22, a);
        cyc(1'b1, 8'h33, a);
        n = 0;
        while (wave.size() != 0 && n < 100) begin
            cyc(1'b0, 8'h00, a);
            n++;
        end
        chk("pp_before", int'(fifo_count), 2);
        cyc(1'b1, 8'h44, a);
        chk("pp_after", int'(fifo_count), 2);
        drain("drain_pp");

        cyc(1'b1, 8'h3C, a);
        cyc(1'b1, 8'h5A, a);
        cyc(1'b1, 8'h96, a);
        n = 0;
        while (wave.size() > 22 && n < 100) begin
            cyc(1'b0, 8'h00, a);
            n++;
        end
        chk("bit3_count", int'(fifo_count), 2);
        #2 rst = 1'b0;
        #1 chk_reset("rst_mid");
        @(posedge clk);
        #1 chk_reset("rst_mid_hold");
        #1 rst = 1'b1;
        model_reset();
        repeat (60) cyc(1'b0, 8'h00, a);

        cyc(1'b1, 8'h00, a);
        cyc(1'b0, 8'h00, a);
        cyc(1'b0, 8'h00, a);
        chk("start_tx_low", int'(tx), 0);
        #2 rst = 1'b0;
        #1 chk_reset("rst_start");
        #2 rst = 1'b1;
        model_reset();
        repeat (20) cyc(1'b0, 8'h00, a);

        for (int i = 0; i < 1500; i++) begin
            int pct;
            pct = ((i / 250) % 3 == 0) ? 5 : ((i / 250) % 3 == 1) ? 30 : 90;
            cyc($urandom_range(0, 99) < pct, 8'($urandom), a);
        end
        drain("drain_random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
